// File: rtl/serial_to_bus_expander_8.sv
// Serial-to-parallel expander: assembles 8 accepted serial bits into a byte and
// presents it through a holding register with per-bit output inversion.
module serial_to_bus_expander_8 #(
    parameter logic [7:0] BubblesMask = 8'h00,
    parameter bit         LsbFirst    = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Clear,
    input  logic       Serial_In,
    input  logic       Serial_Valid,
    output logic       Serial_Ready,
    output logic [7:0] Result,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [2:0] Bit_Count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] assembled;
    logic [2:0] pos;
    logic       last_bit;
    logic       acc;
    logic       take;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        hold_d   = hold_q;

        last_bit     = (cnt_q == 3'd7);
        Out_Valid    = (state_q == HOLD);
        // Only the byte-completing bit must wait for the holding register to free up.
        Serial_Ready = ~(last_bit & Out_Valid & ~Out_Ready) & ~Clear;
        acc          = Serial_Valid & Serial_Ready;
        take         = Out_Valid & Out_Ready;

        pos            = LsbFirst ? cnt_q : (3'd7 - cnt_q);
        assembled      = shift_q;
        assembled[pos] = Serial_In;

        if (Clear) begin
            state_d = COLLECT;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            if (acc) begin
                cnt_d = cnt_q + 3'd1;
                if (last_bit) begin
                    hold_d  = assembled;
                    shift_d = '0;
                end else begin
                    shift_d = assembled;
                end
            end
            // Completion wins over a simultaneous take: the old byte leaves, the new one loads.
            if (acc && last_bit) begin
                state_d = HOLD;
            end else if (take) begin
                state_d = COLLECT;
            end
        end
    end

    assign Result    = hold_q ^ BubblesMask;
    assign Bit_Count = cnt_q;

endmodule

// File: tb/tb_serial_to_bus_expander_8.sv
// Directed and randomized checks of serial_to_bus_expander_8 across several
// parameterizations sharing one stimulus stream.
module tb_serial_to_bus_expander_8;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       ser_in;
    logic       ser_valid;
    logic       out_ready;

    logic       rdy_f0, rdy_lsb, rdy_msb, rdy_a5;
    logic [7:0] res_f0, res_lsb, res_msb, res_a5;
    logic       ov_f0, ov_lsb, ov_msb, ov_a5;
    logic [2:0] cnt_f0, cnt_lsb, cnt_msb, cnt_a5;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_to_bus_expander_8 #(.BubblesMask(8'hF0), .LsbFirst(1'b1)) u_f0 (
        .Clock(clk), .Reset_n(rst_n), .Clear(clear), .Serial_In(ser_in),
        .Serial_Valid(ser_valid), .Serial_Ready(rdy_f0), .Result(res_f0),
        .Out_Valid(ov_f0), .Out_Ready(out_ready), .Bit_Count(cnt_f0));

    serial_to_bus_expander_8 #(.BubblesMask(8'h00), .LsbFirst(1'b1)) u_lsb (
        .Clock(clk), .Reset_n(rst_n), .Clear(clear), .Serial_In(ser_in),
        .Serial_Valid(ser_valid), .Serial_Ready(rdy_lsb), .Result(res_lsb),
        .Out_Valid(ov_lsb), .Out_Ready(out_ready), .Bit_Count(cnt_lsb));

    serial_to_bus_expander_8 #(.BubblesMask(8'h00), .LsbFirst(1'b0)) u_msb (
        .Clock(clk), .Reset_n(rst_n), .Clear(clear), .Serial_In(ser_in),
        .Serial_Valid(ser_valid), .Serial_Ready(rdy_msb), .Result(res_msb),
        .Out_Valid(ov_msb), .Out_Ready(out_ready), .Bit_Count(cnt_msb));

    serial_to_bus_expander_8 #(.BubblesMask(8'hA5), .LsbFirst(1'b1)) u_a5 (
        .Clock(clk), .Reset_n(rst_n), .Clear(clear), .Serial_In(ser_in),
        .Serial_Valid(ser_valid), .Serial_Ready(rdy_a5), .Result(res_a5),
        .Out_Valid(ov_a5), .Out_Ready(out_ready), .Bit_Count(cnt_a5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_in    = b[i];
            step();
        end
        ser_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (res_f0 !== 8'hF0) $display("FAIL reset_result: got %h expected %h", res_f0, 8'hF0);
        else pass_cnt++;
        total_cnt++;
        if (ov_f0 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov_f0);
        else pass_cnt++;
        total_cnt++;
        if (rdy_f0 !== 1'b1) $display("FAIL reset_serial_ready: got %b expected 1", rdy_f0);
        else pass_cnt++;

        ser_valid = 1'b1;
        ser_in    = 1'b1;
        repeat (3) step();
        ser_valid = 1'b0;
        total_cnt++;
        if (cnt_f0 !== 3'd3) $display("FAIL partial_count: got %0d expected 3", cnt_f0);
        else pass_cnt++;

        // assert reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (cnt_f0 !== 3'd0) $display("FAIL async_reset_count: got %0d expected 0", cnt_f0);
        else pass_cnt++;
        total_cnt++;
        if (res_f0 !== 8'hF0) $display("FAIL async_reset_result: got %h expected %h", res_f0, 8'hF0);
        else pass_cnt++;
        total_cnt++;
        if (ov_f0 !== 1'b0) $display("FAIL async_reset_out_valid: got %b expected 0", ov_f0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bit_order();
        logic [7:0] stream;
        stream = 8'h4D;  // first-sent bit in [0]: 1,0,1,1,0,0,1,0
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_in    = stream[i];
            step();
            if (i == 6) begin
                total_cnt++;
                if (ov_lsb !== 1'b0) $display("FAIL early_out_valid: got %b expected 0", ov_lsb);
                else pass_cnt++;
            end
        end
        ser_valid = 1'b0;
        total_cnt++;
        if (res_lsb !== 8'h4D) $display("FAIL lsb_first_result: got %h expected %h", res_lsb, 8'h4D);
        else pass_cnt++;
        total_cnt++;
        if (ov_lsb !== 1'b1) $display("FAIL lsb_out_valid: got %b expected 1", ov_lsb);
        else pass_cnt++;
        total_cnt++;
        if (res_msb !== 8'hB2) $display("FAIL msb_first_result: got %h expected %h", res_msb, 8'hB2);
        else pass_cnt++;
        total_cnt++;
        if (cnt_lsb !== 3'd0) $display("FAIL count_wrap: got %0d expected 0", cnt_lsb);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ov_lsb !== 1'b0) $display("FAIL out_valid_after_take: got %b expected 0", ov_lsb);
        else pass_cnt++;
    endtask

    task automatic test_backpressure_take();
        logic [7:0] b;
        int         early_drop;
        int         takes;
        b          = 8'h22;
        early_drop = 0;
        takes      = 0;
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h11);
        total_cnt++;
        if (res_lsb !== 8'h11 || ov_lsb !== 1'b1)
            $display("FAIL byte_a_held: got %h/%b expected 11/1", res_lsb, ov_lsb);
        else pass_cnt++;

        for (int i = 0; i < 7; i++) begin
            ser_valid = 1'b1;
            ser_in    = b[i];
            #1;
            if (rdy_lsb !== 1'b1) early_drop++;
            step();
        end
        total_cnt++;
        if (early_drop != 0) $display("FAIL ready_dropped_early: got %0d drops expected 0", early_drop);
        else pass_cnt++;

        ser_in = b[7];
        #1;
        total_cnt++;
        if (rdy_lsb !== 1'b0) $display("FAIL ready_stall_bit7: got %b expected 0", rdy_lsb);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if (res_lsb !== 8'h11 || ov_lsb !== 1'b1 || cnt_lsb !== 3'd7)
            $display("FAIL stall_stable: got %h/%b/%0d expected 11/1/7", res_lsb, ov_lsb, cnt_lsb);
        else pass_cnt++;

        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (rdy_lsb !== 1'b1) $display("FAIL ready_on_take: got %b expected 1", rdy_lsb);
        else pass_cnt++;
        if (ov_lsb && out_ready) takes++;
        step();
        ser_valid = 1'b0;
        total_cnt++;
        if (ov_lsb !== 1'b1 || res_lsb !== 8'h22)
            $display("FAIL take_and_complete: got %h/%b expected 22/1", res_lsb, ov_lsb);
        else pass_cnt++;
        if (ov_lsb && out_ready) takes++;
        step();
        if (ov_lsb && out_ready) takes++;
        step();
        total_cnt++;
        if (takes != 2) $display("FAIL consumer_byte_count: got %0d expected 2", takes);
        else pass_cnt++;
        total_cnt++;
        if (ov_lsb !== 1'b0) $display("FAIL drained_out_valid: got %b expected 0", ov_lsb);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h11);
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        repeat (5) step();
        total_cnt++;
        if (cnt_lsb !== 3'd5) $display("FAIL pre_clear_count: got %0d expected 5", cnt_lsb);
        else pass_cnt++;
        clear = 1'b1;
        #1;
        total_cnt++;
        if (rdy_lsb !== 1'b0) $display("FAIL ready_during_clear: got %b expected 0", rdy_lsb);
        else pass_cnt++;
        step();
        clear     = 1'b0;
        ser_valid = 1'b0;
        total_cnt++;
        if (cnt_lsb !== 3'd0 || ov_lsb !== 1'b0)
            $display("FAIL clear_state: got %0d/%b expected 0/0", cnt_lsb, ov_lsb);
        else pass_cnt++;
        total_cnt++;
        if (res_lsb !== 8'h11) $display("FAIL clear_keeps_hold: got %h expected %h", res_lsb, 8'h11);
        else pass_cnt++;
        out_ready = 1'b1;
        send_byte(8'hFF);
        total_cnt++;
        if (res_lsb !== 8'hFF || res_msb !== 8'hFF || ov_lsb !== 1'b1)
            $display("FAIL post_clear_byte: got %h/%h/%b expected ff/ff/1", res_lsb, res_msb, ov_lsb);
        else pass_cnt++;
        step();
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] model_byte;
        logic       exp_rdy;
        int         model_cnt;
        int         got;
        int         cycles;
        int         rdy_err;
        int         ov_err;
        model_byte = '0;
        model_cnt  = 0;
        got        = 0;
        cycles     = 0;
        rdy_err    = 0;
        ov_err     = 0;
        do_reset();
        while (got < 1000 && cycles < 50000) begin
            ser_valid = ($urandom_range(0, 9) < 7);
            ser_in    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = !(model_cnt == 7 && exp_q.size() != 0 && !out_ready);
            if (rdy_a5 !== exp_rdy) rdy_err++;
            if (ov_a5 !== (exp_q.size() != 0)) ov_err++;
            if (exp_q.size() != 0 && out_ready) begin
                total_cnt++;
                if (res_a5 !== exp_q[0])
                    $display("FAIL random_byte_%0d: got %h expected %h", got, res_a5, exp_q[0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
                got++;
            end
            if (ser_valid && exp_rdy) begin
                model_byte[model_cnt] = ser_in;
                if (model_cnt == 7) begin
                    exp_q.push_back(model_byte ^ 8'hA5);
                    model_byte = '0;
                end
                model_cnt = (model_cnt + 1) % 8;
            end
            step();
            cycles++;
        end
        ser_valid = 1'b0;
        total_cnt++;
        if (got != 1000) $display("FAIL random_byte_budget: got %0d bytes expected 1000", got);
        else pass_cnt++;
        total_cnt++;
        if (rdy_err != 0) $display("FAIL random_serial_ready: got %0d bad cycles expected 0", rdy_err);
        else pass_cnt++;
        total_cnt++;
        if (ov_err != 0) $display("FAIL random_out_valid: got %0d bad cycles expected 0", ov_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_backpressure_take();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
